rhs_chip_emulator: RTL and testbench

RHS_CHIP_EMULATOR -- requirements
Module: rhs_chip_emulator

---
 rtl/rhs_chip_emulator_if.sv | 32 +++
 rtl/rhs_chip_emulator.sv | 132 +++++++++++++
 tb/tb_rhs_chip_emulator.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rhs_chip_emulator_if.sv
// SPI pins and command/status outputs of the RHS chip emulator, grouped as one bundle.
// Optional MISO_oe output exists only when RHS_EMU_TRISTATE_EN is defined.
interface rhs_chip_emulator_if;
    logic        SCLK;
    logic        CS;
    logic        MOSI;
    logic        MISO;
`ifdef RHS_EMU_TRISTATE_EN
    logic        MISO_oe;
`endif
    logic        cmd_valid;
    logic [31:0] cmd_word;
    logic [15:0] frame_count;

    modport master (
        output SCLK, CS, MOSI,
        input  MISO,
`ifdef RHS_EMU_TRISTATE_EN
        input  MISO_oe,
`endif
        input  cmd_valid, cmd_word, frame_count
    );

    modport slave (
        input  SCLK, CS, MOSI,
        output MISO,
`ifdef RHS_EMU_TRISTATE_EN
        output MISO_oe,
`endif
        output cmd_valid, cmd_word, frame_count
    );
endinterface

// File: rtl/rhs_chip_emulator.sv
// SPI slave emulating an RHS-style acquisition chip: 32-bit commands, 2-deep response pipe.
// Define RHS_EMU_TRISTATE_EN to expose MISO_oe instead of forcing MISO low while CS is high.
module rhs_chip_emulator #(
    parameter int unsigned STARTING_SEED = 0,
    parameter int unsigned NUM_REGS      = 32
) (
    input logic               clk,
    input logic               rst,
    rhs_chip_emulator_if.slave bus
);
    localparam logic [7:0] Seed8 = 8'(STARTING_SEED);

    logic sclk_s1_q, sclk_s2_q, sclk_d1_q;
    logic cs_s1_q, cs_s2_q, cs_d1_q;
    logic mosi_s1_q, mosi_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1_q <= 1'b0; sclk_s2_q <= 1'b0; sclk_d1_q <= 1'b0;
            cs_s1_q   <= 1'b1; cs_s2_q   <= 1'b1; cs_d1_q   <= 1'b1;
            mosi_s1_q <= 1'b0; mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= bus.SCLK; sclk_s2_q <= sclk_s1_q; sclk_d1_q <= sclk_s2_q;
            cs_s1_q   <= bus.CS;   cs_s2_q   <= cs_s1_q;   cs_d1_q   <= cs_s2_q;
            mosi_s1_q <= bus.MOSI; mosi_s2_q <= mosi_s1_q;
        end
    end

    logic cs_low, sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign cs_low    = ~cs_s2_q;
    assign sclk_rise = sclk_s2_q & ~sclk_d1_q;
    assign sclk_fall = ~sclk_s2_q & sclk_d1_q;
    assign cs_fall   = ~cs_s2_q & cs_d1_q;
    assign cs_rise   = cs_s2_q & ~cs_d1_q;

    logic [31:0] shift_q, out_sr_q, pipe0_q, pipe1_q, cmd_word_q;
    logic [5:0]  bit_cnt_q;
    logic        cmd_valid_q;
    logic [15:0] frame_q;
    logic [15:0] regs_q [NUM_REGS];

    logic        accept, is_clear, wr_en, fc_inc;
    logic [3:0]  chan;
    logic [7:0]  addr;
    logic [15:0] rd_val;
    logic [31:0] resp;

    assign accept   = cs_rise && (bit_cnt_q == 6'd32);
    assign is_clear = (shift_q == 32'h6A00_0000);
    assign chan     = shift_q[19:16];
    assign addr     = shift_q[23:16];
    assign wr_en    = accept && (shift_q[31:30] == 2'b10);
    assign fc_inc   = accept && !shift_q[31] && !is_clear && (chan == 4'hF);

    always_comb begin
        rd_val = 16'h0000;
        case (addr)
            8'd251:  rd_val = 16'h0049;
            8'd252:  rd_val = 16'h004E;
            8'd253:  rd_val = 16'h0054;
            8'd254:  rd_val = 16'h0041;
            8'd255:  rd_val = 16'h0020;
            default: rd_val = 16'h0000;
        endcase
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (addr == 8'(i)) rd_val = regs_q[i];
        end
    end

    always_comb begin
        resp = 32'h0;
        unique case (shift_q[31:30])
            2'b00, 2'b01: resp = is_clear ? 32'h0
                                          : {6'b0, 10'h200, Seed8 + {4'b0, chan}, frame_q[7:0]};
            2'b10:        resp = {16'hFFFF, shift_q[15:0]};
            2'b11:        resp = {16'h0000, rd_val};
            default:      resp = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q     <= 32'h0;
            out_sr_q    <= 32'h0;
            bit_cnt_q   <= 6'd0;
            pipe0_q     <= 32'h0;
            pipe1_q     <= 32'h0;
            cmd_word_q  <= 32'h0;
            cmd_valid_q <= 1'b0;
            frame_q     <= 16'h0;
        end else begin
            cmd_valid_q <= 1'b0;
            if (cs_fall) begin
                bit_cnt_q <= 6'd0;
                out_sr_q  <= pipe1_q;
            end else if (cs_low && sclk_rise) begin
                shift_q <= {shift_q[30:0], mosi_s2_q};
                if (bit_cnt_q != 6'h3F) bit_cnt_q <= bit_cnt_q + 6'd1;
            end else if (cs_low && sclk_fall) begin
                out_sr_q <= {out_sr_q[30:0], 1'b0};
            end
            // Partial words never reach here, so the pipe only moves on complete commands.
            if (accept) begin
                cmd_valid_q <= 1'b1;
                cmd_word_q  <= shift_q;
                pipe0_q     <= resp;
                pipe1_q     <= pipe0_q;
                if (fc_inc) frame_q <= frame_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= 16'h0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (wr_en && (addr == 8'(i))) regs_q[i] <= shift_q[15:0];
            end
        end
    end

    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_word    = cmd_word_q;
    assign bus.frame_count = frame_q;
`ifdef RHS_EMU_TRISTATE_EN
    assign bus.MISO    = out_sr_q[31];
    assign bus.MISO_oe = cs_low;
`else
    assign bus.MISO    = out_sr_q[31] & cs_low;
`endif
endmodule

// File: tb/tb_rhs_chip_emulator.sv
// Directed bench for rhs_chip_emulator: seed-0 and seed-16 instances share the same SPI host.
module tb_rhs_chip_emulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rhs_chip_emulator_if bus0 ();
    rhs_chip_emulator_if bus16 ();
    assign bus16.SCLK = bus0.SCLK;
    assign bus16.CS   = bus0.CS;
    assign bus16.MOSI = bus0.MOSI;

    rhs_chip_emulator #(.STARTING_SEED(0), .NUM_REGS(32)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    rhs_chip_emulator #(.STARTING_SEED(16), .NUM_REGS(32)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16)
    );

    int vectors     = 0;
    int miscompares = 0;
    int valid_cnt   = 0;

    always @(posedge clk) if (bus0.cmd_valid === 1'b1) valid_cnt <= valid_cnt + 1;

    logic [31:0] seq [$];
    logic [31:0] rx0 [32];
    logic [31:0] rx16 [32];

    localparam logic [31:0] Clr = 32'h6A00_0000;

    // Host timing keeps all pin changes and samples on t % 10 == 0, away from clk rises.
    task automatic spi_word(input logic [31:0] tx, input int nbits,
                            output logic [31:0] r0, output logic [31:0] r16);
        r0  = '0;
        r16 = '0;
        bus0.CS = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            bus0.MOSI = tx[31-i];
            #60;
            r0[31-i]  = bus0.MISO;
            r16[31-i] = bus16.MISO;
            bus0.SCLK = 1'b1;
            #60;
            bus0.SCLK = 1'b0;
        end
        #60;
        bus0.CS   = 1'b1;
        bus0.MOSI = 1'b0;
        #100;
    endtask

    task automatic run_seq();
        for (int i = 0; i < seq.size(); i++) spi_word(seq[i], 32, rx0[i], rx16[i]);
        seq.delete();
    endtask

    task automatic do_reset();
        bus0.CS = 1'b1; bus0.SCLK = 1'b0; bus0.MOSI = 1'b0;
        rst = 1'b1;
        #40;
        rst = 1'b0;
        #40;
    endtask

    task automatic test_reset();
        bus0.CS = 1'b1; bus0.SCLK = 1'b0; bus0.MOSI = 1'b0;
        rst = 1'b1;
        #40;
        vectors++;
        if (bus0.MISO !== 1'b0) begin
            miscompares++; $display("FAIL reset_miso_in_rst: got %b want 0", bus0.MISO);
        end
        rst = 1'b0;
        #40;
        vectors++;
        if (bus0.cmd_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_cmd_valid: got %b want 0", bus0.cmd_valid);
        end
        vectors++;
        if (bus0.cmd_word !== 32'h0) begin
            miscompares++; $display("FAIL reset_cmd_word: got %h want 00000000", bus0.cmd_word);
        end
        vectors++;
        if (bus0.frame_count !== 16'h0) begin
            miscompares++; $display("FAIL reset_frame_count: got %h want 0000", bus0.frame_count);
        end
    endtask

    task automatic test_read_id();
        int v0;
        do_reset();
        v0 = valid_cnt;
        seq = '{32'hC0FF_0000, Clr, Clr};
        run_seq();
        vectors++;
        if (rx0[0] !== 32'h0 || rx0[1] !== 32'h0) begin
            miscompares++; $display("FAIL read_id_first_two: got %h %h want 0 0", rx0[0], rx0[1]);
        end
        vectors++;
        if (rx0[2] !== 32'h0000_0020) begin
            miscompares++; $display("FAIL read_id_255: got %h want 00000020", rx0[2]);
        end
        vectors++;
        if (valid_cnt - v0 !== 3) begin
            miscompares++; $display("FAIL read_id_valid_pulses: got %0d want 3", valid_cnt - v0);
        end
        vectors++;
        if (bus0.cmd_word !== Clr) begin
            miscompares++; $display("FAIL read_id_cmd_word: got %h want 6a000000", bus0.cmd_word);
        end
    endtask

    task automatic test_convert();
        do_reset();
        seq = '{32'h0003_0000, Clr, Clr};
        run_seq();
        vectors++;
        if (rx16[2] !== 32'h0200_1300) begin
            miscompares++; $display("FAIL convert_seed16_ch3: got %h want 02001300", rx16[2]);
        end
        vectors++;
        if (rx0[2] !== 32'h0200_0300) begin
            miscompares++; $display("FAIL convert_seed0_ch3: got %h want 02000300", rx0[2]);
        end
        do_reset();
        seq = '{32'h4005_0000, Clr, Clr};
        run_seq();
        vectors++;
        if (rx0[2] !== 32'h0200_0500) begin
            miscompares++; $display("FAIL convert_alias_01: got %h want 02000500", rx0[2]);
        end
    endtask

    task automatic test_frames();
        do_reset();
        for (int c = 0; c < 16; c++) seq.push_back({12'h0, 4'(c), 16'h0});
        seq.push_back(32'h0000_0000);
        seq.push_back(Clr);
        seq.push_back(Clr);
        run_seq();
        vectors++;
        if (rx0[2] !== 32'h0200_0000) begin
            miscompares++; $display("FAIL frames_ch0_resp: got %h want 02000000", rx0[2]);
        end
        vectors++;
        if (rx0[17] !== 32'h0200_0F00) begin
            miscompares++; $display("FAIL frames_ch15_resp: got %h want 02000f00", rx0[17]);
        end
        vectors++;
        if (rx0[18] !== 32'h0200_0001) begin
            miscompares++; $display("FAIL frames_after_wrap: got %h want 02000001", rx0[18]);
        end
        vectors++;
        if (rx16[18] !== 32'h0200_1001) begin
            miscompares++; $display("FAIL frames_seed16: got %h want 02001001", rx16[18]);
        end
        vectors++;
        if (bus0.frame_count !== 16'h0001) begin
            miscompares++; $display("FAIL frames_count: got %h want 0001", bus0.frame_count);
        end
    endtask

    task automatic test_write_read();
        do_reset();
        seq = '{32'h8005_BEEF, 32'hC005_0000, Clr, Clr};
        run_seq();
        vectors++;
        if (rx0[2] !== 32'hFFFF_BEEF) begin
            miscompares++; $display("FAIL write_resp: got %h want ffffbeef", rx0[2]);
        end
        vectors++;
        if (rx0[3] !== 32'h0000_BEEF) begin
            miscompares++; $display("FAIL read_back: got %h want 0000beef", rx0[3]);
        end
    endtask

    task automatic test_abort();
        int v0;
        logic [31:0] p0, p16;
        do_reset();
        seq = '{32'h8003_A5A5, Clr};
        run_seq();
        v0 = valid_cnt;
        spi_word(32'hC0FB_0000, 16, p0, p16);
        vectors++;
        if (p0 !== 32'hFFFF_0000) begin
            miscompares++; $display("FAIL abort_partial_out: got %h want ffff0000", p0);
        end
        vectors++;
        if (valid_cnt !== v0) begin
            miscompares++; $display("FAIL abort_no_valid: got %0d want %0d", valid_cnt, v0);
        end
`ifdef RHS_EMU_TRISTATE_EN
        vectors++;
        if (bus0.MISO_oe !== 1'b0) begin
            miscompares++; $display("FAIL abort_oe_cs_high: got %b want 0", bus0.MISO_oe);
        end
`else
        vectors++;
        if (bus0.MISO !== 1'b0) begin
            miscompares++; $display("FAIL abort_miso_cs_high: got %b want 0", bus0.MISO);
        end
`endif
        seq = '{32'hC0FB_0000, Clr, Clr};
        run_seq();
        vectors++;
        if (rx0[0] !== 32'hFFFF_A5A5) begin
            miscompares++; $display("FAIL abort_restart_head: got %h want ffffa5a5", rx0[0]);
        end
        vectors++;
        if (rx0[2] !== 32'h0000_0049) begin
            miscompares++; $display("FAIL abort_read_251: got %h want 00000049", rx0[2]);
        end
        vectors++;
        if (valid_cnt - v0 !== 3) begin
            miscompares++; $display("FAIL abort_valid_count: got %0d want 3", valid_cnt - v0);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        seq = '{32'h8005_BEEF, 32'h8028_1234, 32'hC028_0000, 32'hC005_0000,
                32'hC0FE_0000, 32'hC064_0000, Clr, Clr};
        run_seq();
        vectors++;
        if (rx0[3] !== 32'hFFFF_1234) begin
            miscompares++; $display("FAIL oor_write_resp: got %h want ffff1234", rx0[3]);
        end
        vectors++;
        if (rx0[4] !== 32'h0) begin
            miscompares++; $display("FAIL oor_read_40: got %h want 00000000", rx0[4]);
        end
        vectors++;
        if (rx0[5] !== 32'h0000_BEEF) begin
            miscompares++; $display("FAIL oor_reg5_kept: got %h want 0000beef", rx0[5]);
        end
        vectors++;
        if (rx0[6] !== 32'h0000_0041) begin
            miscompares++; $display("FAIL read_254: got %h want 00000041", rx0[6]);
        end
        vectors++;
        if (rx0[7] !== 32'h0) begin
            miscompares++; $display("FAIL read_100: got %h want 00000000", rx0[7]);
        end
    endtask

    initial begin
        test_reset();
        test_read_id();
        test_convert();
        test_frames();
        test_write_read();
        test_abort();
        test_out_of_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
